// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - SVGA 800x600@60 timing constants and rectangle colours
package vga_pkg;

  localparam int HOR_TOTAL_TIME  = 1056;
  localparam int HOR_BLANK_START = 800;
  localparam int HOR_SYNC_START  = 840;
  localparam int HOR_SYNC_TIME   = 128;
  localparam int VER_TOTAL_TIME  = 628;
  localparam int VER_BLANK_START = 600;
  localparam int VER_SYNC_START  = 601;
  localparam int VER_SYNC_TIME   = 4;

  localparam int HOR_PIXELS = 800;
  localparam int VER_PIXELS = 600;

  localparam logic [11:0] RECT_COLOR_DEFAULT = 12'hF_0_0;
  localparam logic [11:0] RECT_BORDER_COLOR  = 12'hF_F_F;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_bus_t;

endpackage

// File: rtl/vga_if.sv
// rtl/vga_if.sv - VGA timing/pixel bus between video pipeline stages
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_rect_pos_latch.sv
// rtl/draw_rect_pos_latch.sv - captures rectangle position on each vblnk rising edge
module draw_rect_pos_latch (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblnk,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  output logic [11:0] x_l,
  output logic [11:0] y_l
);

  logic vblnk_prev;

  // Position only moves at the start of vertical blanking, so a frame never tears.
  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_prev <= 1'b0;
      x_l        <= '0;
      y_l        <= '0;
    end else begin
      vblnk_prev <= vblnk;
      if (vblnk && !vblnk_prev) begin
        x_l <= xpos;
        y_l <= ypos;
      end
    end
  end

endmodule

// File: rtl/draw_rect.sv
// rtl/draw_rect.sv - 2-stage rectangle overlay; DRAW_RECT_BORDER_EN adds a 2-pixel border ring
module draw_rect
  import vga_pkg::*;
#(
  parameter int          RECT_W     = 48,
  parameter int          RECT_H     = 64,
  parameter logic [11:0] RECT_COLOR = RECT_COLOR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  vga_if.slave        vga_in,
  vga_if.master       vga_out
);

  localparam logic [11:0] W12 = 12'(RECT_W);
  localparam logic [11:0] H12 = 12'(RECT_H);

  logic [11:0] x_l, y_l;
  logic [11:0] h12, v12;
  logic        pos_ok, inside_c;
  vga_bus_t    s1, out_q;
  logic        inside_q;

  draw_rect_pos_latch u_pos_latch (
    .clk   (clk),
    .rst   (rst),
    .vblnk (vga_in.vblnk),
    .xpos  (xpos),
    .ypos  (ypos),
    .x_l   (x_l),
    .y_l   (y_l)
  );

  assign h12 = {1'b0, vga_in.hcount};
  assign v12 = {1'b0, vga_in.vcount};

  // An off-screen origin draws nothing; it also keeps x_l+W12 from wrapping 12 bits.
  assign pos_ok   = (x_l < 12'(HOR_PIXELS)) && (y_l < 12'(VER_PIXELS));
  assign inside_c = pos_ok &&
                    (h12 >= x_l) && (h12 < x_l + W12) &&
                    (v12 >= y_l) && (v12 < y_l + H12);

`ifdef DRAW_RECT_BORDER_EN
  logic ring_c, ring_q;
  assign ring_c = (h12 < x_l + 12'd2) || (h12 + 12'd2 >= x_l + W12) ||
                  (v12 < y_l + 12'd2) || (v12 + 12'd2 >= y_l + H12);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= '0;
      inside_q <= 1'b0;
      out_q    <= '0;
`ifdef DRAW_RECT_BORDER_EN
      ring_q   <= 1'b0;
`endif
    end else begin
      s1       <= '{vga_in.hcount, vga_in.vcount, vga_in.hsync, vga_in.vsync,
                    vga_in.hblnk, vga_in.vblnk, vga_in.rgb};
      inside_q <= inside_c;
`ifdef DRAW_RECT_BORDER_EN
      ring_q   <= ring_c;
`endif
      out_q    <= s1;
      if (inside_q && !s1.hblnk && !s1.vblnk) begin
`ifdef DRAW_RECT_BORDER_EN
        out_q.rgb <= ring_q ? RECT_BORDER_COLOR : RECT_COLOR;
`else
        out_q.rgb <= RECT_COLOR;
`endif
      end
    end
  end

  assign vga_out.hcount = out_q.hcount;
  assign vga_out.vcount = out_q.vcount;
  assign vga_out.hsync  = out_q.hsync;
  assign vga_out.vsync  = out_q.vsync;
  assign vga_out.hblnk  = out_q.hblnk;
  assign vga_out.vblnk  = out_q.vblnk;
  assign vga_out.rgb    = out_q.rgb;

endmodule

// File: doc/draw_rect.md
DRAW_RECT -- requirements
Module: draw_rect

Interface
REQ-001 Parameter RECT_W, default 48, means rectangle width in pixels (1..800).
REQ-002 Parameter RECT_H, default 64, means rectangle height in lines (1..600).
REQ-003 Parameter RECT_COLOR, default 12'hF_0_0, means 12-bit RGB fill colour.
REQ-004 The port list SHALL be:
- clk  input  1  system clock, 40 MHz pixel clock.
- rst  input  1  reset; synchronous, active-high.
- xpos  input  12  requested rectangle left edge, in pixels.
- ypos  input  12  requested rectangle top edge, in lines.
- vga_in  vga_if input modport  carries hcount[10:0], vcount[10:0], hsync, vsync, hblnk, vblnk, rgb[11:0] from upstream.
- vga_out  vga_if output modport  carries the same fields downstream.

Function
REQ-005 The block SHALL be a 2-stage pipeline: every field of vga_out SHALL equal the corresponding vga_in field from exactly 2 clk cycles earlier, except rgb.
REQ-006 Stage 1 SHALL register the vga_in fields together with a 1-bit inside flag.
- inside = (hcount >= x_l) && (hcount < x_l+RECT_W) && (vcount >= y_l) && (vcount < y_l+RECT_H).
- Compare at 12-bit width so that x_l+RECT_W cannot wrap.
REQ-007 Stage 2 SHALL output vga_out.rgb as follows:
- RECT_COLOR when the stage-1 inside flag = 1 and both hblnk and vblnk = 0.
- Otherwise the delayed vga_in.rgb.
REQ-008 x_l and y_l SHALL be internal registers that capture xpos and ypos on the cycle in which a vblnk rising edge is detected (vga_in.vblnk = 1 and the registered previous vblnk = 0).
REQ-009 Changes to xpos or ypos outside that cycle SHALL NOT alter the picture until the next vblnk rising edge; this prevents tearing.
REQ-010 If a rectangle extends beyond hcount 799 or vcount 599, the excess SHALL be clipped naturally: no wrap to the left or top edge, and sync and blank pass through unchanged.
REQ-011 If xpos >= 800 or ypos >= 600, the block SHALL draw nothing.
REQ-012 RGB override SHALL NOT occur during blanking, even if the rectangle geometrically covers blank coordinates.

Reset
REQ-013 While rst = 1, on every clk edge the block SHALL clear the following to 0: all vga_out fields, all stage-1 registers, x_l, y_l, and the previous-vblnk register.
REQ-014 After rst deasserts mid-frame, vga_out SHALL carry valid delayed data from the 2nd clk edge onward.
REQ-015 After rst deasserts, x_l and y_l SHALL remain 0 until the first subsequent vblnk rising edge.

Configuration
REQ-016 When DRAW_RECT_BORDER_EN is defined, the block SHALL draw pixels in the outermost 2-pixel ring of the rectangle with the border colour.
- Ring = columns x_l, x_l+1, x_l+RECT_W-2, x_l+RECT_W-1, and the equivalent rows.
- Border colour = RECT_BORDER_COLOR, a package constant with value 12'hF_F_F.
- The interior uses RECT_COLOR.
REQ-017 When DRAW_RECT_BORDER_EN is undefined, the whole rectangle SHALL be RECT_COLOR and no border logic SHALL be synthesised.
REQ-018 Latency SHALL be 2 cycles in both configurations.

Structure
REQ-019 The following SHALL live in vga_pkg alongside the existing timing constants:
- HOR_PIXELS = 800, VER_PIXELS = 600.
- The default RECT_COLOR.
- RECT_BORDER_COLOR.
REQ-020 The vblnk edge detector and x_l/y_l latch SHALL be a sub-module named draw_rect_pos_latch, with ports clk, rst, vblnk, xpos, ypos, x_l, y_l.
REQ-021 The remainder of the block SHALL be a single module instantiating draw_rect_pos_latch.

Verification
REQ-022 The bench SHALL drive vga_in from vga_timing with vga_in.rgb = 12'h0_0_0, and SHALL cover:
- Pass-through: xpos=1000 → for one full frame, vga_out equals vga_in delayed by 2 cycles on every field.
- Basic draw: xpos=100, ypos=200 held across a vblnk edge → next frame, rgb=12'hF00 exactly for hcount 100..147 and vcount 200..263; count = 3072 pixels per frame.
- Anti-tearing: change xpos from 100 to 300 at vcount=250 → the current frame keeps left edge 100; the following frame has left edge 300.
- Clipping: xpos=780, ypos=580 → 20×20 = 400 coloured pixels; zero coloured pixels during hblnk or vblnk; none at hcount 0..27.
- Reset mid-frame: assert rst for 3 cycles at vcount=300 → vga_out all 0 during reset and for 2 cycles after; the rectangle stays at (0,0) until the next vblnk edge, then appears at the programmed position.
- Border (DRAW_RECT_BORDER_EN defined): xpos=100, ypos=200 → pixel (100,200) = 12'hFFF, pixel (101,201) = 12'hFFF, pixel (102,202) = 12'hF00, pixel (147,263) = 12'hFFF.
